instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
Fetch stage directly upstream of the IF/ID pipeline register. It owns the program counter, issues one instruction-memory request at a time over a req/ready handshake, and presents a registered {pcOut, instructionOut, fetchValid} slot for IF/ID to capture. It supports hazard stalls (hazardPCWrite low), branch/jump redirects, and discarding of in-flight responses after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instructionOut value when no valid instruction (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on posedge
rstN  in  1  synchronous active-low reset
hazardPCWrite  in  1  1 = downstream consumes the slot this cycle / PC may advance; 0 = stall
branchTaken  in  1  single-cycle redirect request from EX (also the flush)
branchTarget  in  32  redirect address; bits[1:0] forced to 0
imemReq  out  1  memory request valid
imemAddr  out  32  memory request address
imemReady  in  1  response valid; completes the current request
imemRdata  in  32  instruction word, valid when imemReady=1
pcOut  out  32  PC of instructionOut
instructionOut  out  32  fetched instruction
fetchValid  out  1  slot holds a valid instruction

Behaviour:
- Reset (rstN=0 at posedge): state=IDLE, pc=RESET_PC, reqAddr=RESET_PC, outstanding=0, fetchValid=0, pcOut=RESET_PC, instructionOut=NOP_INSTR. imemReq=0 during reset and in IDLE. Reset mid-request drops the outstanding request. Memory shares rstN.
- Registers: pc (next fetch address), reqAddr (address of the outstanding request), outstanding flag, output slot, state.
- States:
  - IDLE -> FETCH unconditionally after one cycle. A branchTaken in IDLE loads pc.
  - FETCH: normal operation.
  - DRAIN: a killed request is still outstanding. Go to FETCH on imemReady, discarding the data.
- Request: imemReq = (state!=IDLE) && (outstanding || !fetchValid || hazardPCWrite). imemAddr = outstanding ? reqAddr : pc.
- Once imemReq is high, it and imemAddr are held stable until imemReady. Never deassert or change the address mid-request.
- Issue with no same-cycle ready: outstanding<=1, reqAddr<=pc.
- Accept (FETCH, imemReq&&imemReady, !branchTaken):
  - fetchValid<=1, pcOut<=imemAddr, instructionOut<=imemRdata.
  - pc<=imemAddr+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - outstanding<=0.
  - Zero-latency memory gives 1 instruction/cycle while hazardPCWrite=1.
- Slot consumed (hazardPCWrite=1, no accept): fetchValid<=0, instructionOut<=NOP_INSTR.
- Stall (hazardPCWrite=0, fetchValid=1): slot and pc are held unchanged. No new request is issued; an outstanding one stays held.
- Redirect (branchTaken=1) has priority over stall and accept:
  - pc<=branchTarget&~3, fetchValid<=0, instructionOut<=NOP_INSTR.
  - Response arriving the same cycle is discarded; outstanding<=0; stay in FETCH.
  - Request outstanding and imemReady=0: go to DRAIN. The old request is held until ready, its data discarded. Then fetch starts from the new pc.
  - branchTaken in DRAIN updates pc again; the last target wins.
- Latency: redirect at cycle N -> request to target at N+1 (or after the drain completes) -> valid slot the cycle after imemReady.

Decomposition:
- Shared package riscv_pkg: NOP_INSTR, RESET_PC, ILEN=32, and the enum fetch_state_t {IDLE, FETCH, DRAIN}.
- One sub-module, pc_register: pc storage with synchronous reset, load (redirect), and increment-by-4 / hold controls.

Test Plan:
- Reset with zero-latency memory returning 32'h00A00093@0, 32'h00100113@4, hazardPCWrite=1 -> one idle cycle, then slots (pc 0, 00A00093), (pc 4, 00100113) on consecutive cycles. Before that: fetchValid=0, instructionOut=00000013.
- Stall: hazardPCWrite=0 for 3 cycles with slot (pc 8) valid -> imemReq=0; pcOut=8 and instruction held; resume -> pc 12 fetched next.
- Redirect during a 3-cycle-latency request to addr 16, branchTaken with target 32'h0000_0103 -> imemAddr stays 16 until ready; that response is discarded; next request at 32'h100; fetchValid=0 throughout.
- Same-cycle branchTaken and imemReady -> response dropped; next imemAddr = target.
- Wrap: pc=32'hFFFF_FFFC accepted -> next request at 0.
- rstN low while a request is outstanding -> all outputs at reset values next cycle; first request after IDLE at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end.
// Reset PC, canonical NOP and fetch FSM state encoding.
package riscv_pkg;

    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter: redirect load has priority over +4 increment.
// Redirect targets are forced to word alignment.
module pc_register
    import riscv_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC_P = RESET_PC
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            load,
    input  logic [ILEN-1:0] target,
    input  logic            inc,
    output logic [ILEN-1:0] pc
);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            pc <= RESET_PC_P;
        end else if (load) begin
            pc <= target & ~32'h3;
        end else if (inc) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, issues one imem request at a time
// and presents a registered slot to the IF/ID register.
module instruction_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_PC_P  = RESET_PC,
    parameter logic [ILEN-1:0] NOP_INSTR_P = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            hazardPCWrite,
    input  logic            branchTaken,
    input  logic [ILEN-1:0] branchTarget,
    output logic            imemReq,
    output logic [ILEN-1:0] imemAddr,
    input  logic            imemReady,
    input  logic [ILEN-1:0] imemRdata,
    output logic [ILEN-1:0] pcOut,
    output logic [ILEN-1:0] instructionOut,
    output logic            fetchValid
);

    fetch_state_t    state;
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] reqAddr;
    logic            outstanding;
    logic            handshake;
    logic            accept;

    // In FETCH an outstanding request always targets pc, so +4 on pc
    // equals imemAddr+4.
    assign imemReq   = (state != IDLE) &&
                       (outstanding || !fetchValid || hazardPCWrite);
    assign imemAddr  = outstanding ? reqAddr : pc;
    assign handshake = imemReq && imemReady;
    assign accept    = (state == FETCH) && handshake && !branchTaken;

    pc_register #(
        .RESET_PC_P(RESET_PC_P)
    ) u_pc (
        .clk   (clk),
        .rstN  (rstN),
        .load  (branchTaken),
        .target(branchTarget),
        .inc   (accept),
        .pc    (pc)
    );

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state          <= IDLE;
            reqAddr        <= RESET_PC_P;
            outstanding    <= 1'b0;
            fetchValid     <= 1'b0;
            pcOut          <= RESET_PC_P;
            instructionOut <= NOP_INSTR_P;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (branchTaken) begin
                        fetchValid     <= 1'b0;
                        instructionOut <= NOP_INSTR_P;
                        if (imemReq && !imemReady) begin
                            // Request already on the bus: hold it, drop its data
                            state       <= DRAIN;
                            outstanding <= 1'b1;
                            reqAddr     <= imemAddr;
                        end else begin
                            outstanding <= 1'b0;
                        end
                    end else if (handshake) begin
                        fetchValid     <= 1'b1;
                        pcOut          <= imemAddr;
                        instructionOut <= imemRdata;
                        outstanding    <= 1'b0;
                    end else begin
                        if (imemReq) begin
                            outstanding <= 1'b1;
                            reqAddr     <= imemAddr;
                        end
                        if (hazardPCWrite) begin
                            fetchValid     <= 1'b0;
                            instructionOut <= NOP_INSTR_P;
                        end
                    end
                end
                DRAIN: begin
                    if (imemReady) begin
                        state       <= FETCH;
                        outstanding <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a
// variable-latency instruction memory model.
module tb_instruction_fetch_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic        hazardPCWrite;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemRdata;
    logic [31:0] pcOut;
    logic [31:0] instructionOut;
    logic        fetchValid;

    int unsigned lat;
    int unsigned cnt;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        prev_ok = 1'b0;
    logic        prev_req;
    logic        prev_rdy;
    logic [31:0] prev_addr;

    always #5 clk = ~clk;

    instruction_fetch_stage dut (
        .clk           (clk),
        .rstN          (rstN),
        .hazardPCWrite (hazardPCWrite),
        .branchTaken   (branchTaken),
        .branchTarget  (branchTarget),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .imemReady     (imemReady),
        .imemRdata     (imemRdata),
        .pcOut         (pcOut),
        .instructionOut(instructionOut),
        .fetchValid    (fetchValid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00A0_0093;
            32'h4:   return 32'h0010_0113;
            default: return a ^ 32'h1357_0000;
        endcase
    endfunction

    assign imemReady = imemReq && (cnt == lat);
    assign imemRdata = mem_word(imemAddr);

    always @(posedge clk) begin
        if (!rstN || !imemReq || imemReady) cnt <= 0;
        else cnt <= cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A pending request must keep req and address until ready.
    always @(negedge clk) begin
        if (rstN && prev_ok && prev_req && !prev_rdy) begin
            check("hold_req", {31'd0, imemReq}, 32'd1);
            check("hold_addr", imemAddr, prev_addr);
        end
        prev_ok   <= rstN;
        prev_req  <= imemReq;
        prev_rdy  <= imemReady;
        prev_addr <= imemAddr;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input string tag, input logic [31:0] pc,
                        input logic [31:0] ins);
        check({tag, "_valid"}, {31'd0, fetchValid}, 32'd1);
        check({tag, "_pc"}, pcOut, pc);
        check({tag, "_instr"}, instructionOut, ins);
    endtask

    initial begin
        rstN = 1'b0;
        hazardPCWrite = 1'b1;
        branchTaken = 1'b0;
        branchTarget = 32'h0;
        lat = 0;
        tick;
        tick;
        check("rst_valid", {31'd0, fetchValid}, 32'd0);
        check("rst_instr", instructionOut, NOP_INSTR);
        check("rst_pc", pcOut, RESET_PC);
        check("rst_req", {31'd0, imemReq}, 32'd0);

        rstN = 1'b1;
        #1;
        check("idle_req", {31'd0, imemReq}, 32'd0);
        tick;
        check("first_valid", {31'd0, fetchValid}, 32'd0);
        check("first_instr", instructionOut, 32'h0000_0013);
        check("first_req", {31'd0, imemReq}, 32'd1);
        check("first_addr", imemAddr, 32'h0);
        tick;
        slot("s0", 32'h0, 32'h00A0_0093);
        tick;
        slot("s4", 32'h4, 32'h0010_0113);
        tick;
        slot("s8", 32'h8, 32'h1357_0008);

        hazardPCWrite = 1'b0;
        #1;
        check("stall_req", {31'd0, imemReq}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            slot("stall", 32'h8, 32'h1357_0008);
            check("stall_req_h", {31'd0, imemReq}, 32'd0);
        end
        hazardPCWrite = 1'b1;
        #1;
        check("resume_addr", imemAddr, 32'hC);
        tick;
        slot("s12", 32'hC, 32'h1357_000C);

        lat = 3;
        #1;
        check("lat_addr", imemAddr, 32'h10);
        check("lat_req", {31'd0, imemReq}, 32'd1);
        tick;
        check("lat_valid", {31'd0, fetchValid}, 32'd0);
        branchTaken = 1'b1;
        branchTarget = 32'h0000_0103;
        #1;
        check("br_addr", imemAddr, 32'h10);
        tick;
        branchTaken = 1'b0;
        #1;
        check("drain_addr", imemAddr, 32'h10);
        check("drain_valid", {31'd0, fetchValid}, 32'd0);
        tick;
        check("drain_addr2", imemAddr, 32'h10);
        check("drain_valid2", {31'd0, fetchValid}, 32'd0);
        tick;
        check("post_drain_valid", {31'd0, fetchValid}, 32'd0);
        check("post_drain_addr", imemAddr, 32'h100);
        lat = 0;
        tick;
        slot("s100", 32'h100, 32'h1357_0100);

        branchTaken = 1'b1;
        branchTarget = 32'h200;
        tick;
        branchTaken = 1'b0;
        check("same_valid", {31'd0, fetchValid}, 32'd0);
        check("same_instr", instructionOut, 32'h0000_0013);
        #1;
        check("same_addr", imemAddr, 32'h200);
        tick;
        slot("s200", 32'h200, 32'h1357_0200);

        branchTaken = 1'b1;
        branchTarget = 32'hFFFF_FFFC;
        tick;
        branchTaken = 1'b0;
        #1;
        check("wrap_req_addr", imemAddr, 32'hFFFF_FFFC);
        tick;
        slot("sFFC", 32'hFFFF_FFFC, 32'hECA8_FFFC);
        check("wrap_addr", imemAddr, 32'h0);
        tick;
        slot("wrap0", 32'h0, 32'h00A0_0093);

        lat = 3;
        tick;
        check("mid_valid", {31'd0, fetchValid}, 32'd0);
        rstN = 1'b0;
        tick;
        check("mid_rst_valid", {31'd0, fetchValid}, 32'd0);
        check("mid_rst_pc", pcOut, 32'h0);
        check("mid_rst_instr", instructionOut, 32'h0000_0013);
        check("mid_rst_req", {31'd0, imemReq}, 32'd0);
        rstN = 1'b1;
        lat = 0;
        #1;
        check("mid_idle_req", {31'd0, imemReq}, 32'd0);
        tick;
        check("mid_first_req", {31'd0, imemReq}, 32'd1);
        check("mid_first_addr", imemAddr, 32'h0);
        tick;
        slot("mid_s0", 32'h0, 32'h00A0_0093);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
